// File: rtl/trace_pkg.sv
// Shared trace record layout and constants for the commit trace buffer.
package trace_pkg;

    localparam int unsigned SEQ_W_DEF = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rf_wen;
        logic [31:0] rd_value;
        logic [3:0]  csr_wen;
        logic [31:0] csrd;
    } trace_body_t;

    // Bit layout is {seq, pc, rd, rf_wen, rd_value, csr_wen, csrd}.
    typedef struct packed {
        logic [SEQ_W_DEF-1:0] seq;
        trace_body_t          body;
    } trace_rec_t;

    localparam int unsigned TRACE_W  = $bits(trace_rec_t);
    localparam int unsigned BODY_W   = $bits(trace_body_t);
    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    // Writes to x0 carry no architectural effect, and an absent CSR write carries no data.
    function automatic trace_body_t make_body(
        input logic [31:0] pc,
        input logic [4:0]  rd,
        input logic        rf_wen,
        input logic [31:0] rd_value,
        input logic [3:0]  csr_wen,
        input logic [31:0] csrd
    );
        trace_body_t b;
        b.pc       = pc;
        b.rd       = rd;
        b.rf_wen   = (rd != 5'd0) ? rf_wen : 1'b0;
        b.rd_value = (rd != 5'd0) ? rd_value : '0;
        b.csr_wen  = csr_wen;
        b.csrd     = (csr_wen != 4'd0) ? csrd : '0;
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO with separate occupancy tracking.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is shown straight from storage; an empty FIFO presents zero.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures writeback commits as trace records, queues them and streams them to the trace host.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter bit          STALL_ON_FULL = 1'b1,
    parameter int unsigned SEQ_W         = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wb_valid,
    input  logic [31:0]               wb_pc,
    input  logic [4:0]                wb_rd,
    input  logic                      wb_rf_wen,
    input  logic [31:0]               wb_rd_value,
    input  logic [3:0]                wb_csr_wen,
    input  logic [31:0]               wb_csrd,
    output logic                      wb_ready,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [SEQ_W+BODY_W-1:0]   trace_data,
    output logic [63:0]               retired_cnt,
    output logic [15:0]               dropped_cnt,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int unsigned REC_W = SEQ_W + BODY_W;

    logic [SEQ_W-1:0] seq;
    trace_body_t      body;
    logic [REC_W-1:0] din;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             accept;
    logic             drop;

    always_comb begin
        body = make_body(wb_pc, wb_rd, wb_rf_wen, wb_rd_value, wb_csr_wen, wb_csrd);
        din  = {seq, body};
    end

    // wb_ready deliberately ignores a same-cycle pop so it never depends on trace_ready.
    assign wb_ready    = STALL_ON_FULL ? ~full : 1'b1;
    assign push        = wb_valid & ~full;
    assign accept      = wb_valid & wb_ready;
    assign drop        = accept & full;
    assign trace_valid = ~empty;
    assign pop         = trace_valid & trace_ready;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (trace_data),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq         <= '0;
            retired_cnt <= '0;
            dropped_cnt <= '0;
        end else begin
            if (push) begin
                seq <= seq + SEQ_W'(1);
            end
            if (accept) begin
                retired_cnt <= retired_cnt + 64'd1;
            end
            if (drop && dropped_cnt != DROP_SAT) begin
                dropped_cnt <= dropped_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer in both stall and drop configurations.
module tb_commit_trace_buffer;
    import trace_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_rf_wen;
    logic [31:0] wb_rd_value;
    logic [3:0]  wb_csr_wen;
    logic [31:0] wb_csrd;
    logic        trace_ready;

    logic               s_wb_ready, s_trace_valid;
    logic [TRACE_W-1:0] s_trace_data;
    logic [63:0]        s_retired;
    logic [15:0]        s_dropped;
    logic [3:0]         s_level;

    logic               d_wb_ready, d_trace_valid;
    logic [TRACE_W-1:0] d_trace_data;
    logic [63:0]        d_retired;
    logic [15:0]        d_dropped;
    logic [3:0]         d_level;

    int checks = 0;
    int errors = 0;

    commit_trace_buffer #(.DEPTH(8), .STALL_ON_FULL(1'b1), .SEQ_W(16)) dut_s (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_rf_wen(wb_rf_wen), .wb_rd_value(wb_rd_value), .wb_csr_wen(wb_csr_wen),
        .wb_csrd(wb_csrd), .wb_ready(s_wb_ready), .trace_valid(s_trace_valid),
        .trace_ready(trace_ready), .trace_data(s_trace_data), .retired_cnt(s_retired),
        .dropped_cnt(s_dropped), .fifo_level(s_level)
    );

    commit_trace_buffer #(.DEPTH(8), .STALL_ON_FULL(1'b0), .SEQ_W(16)) dut_d (
        .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_rf_wen(wb_rf_wen), .wb_rd_value(wb_rd_value), .wb_csr_wen(wb_csr_wen),
        .wb_csrd(wb_csrd), .wb_ready(d_wb_ready), .trace_valid(d_trace_valid),
        .trace_ready(trace_ready), .trace_data(d_trace_data), .retired_cnt(d_retired),
        .dropped_cnt(d_dropped), .fifo_level(d_level)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rf_wen;
        logic [31:0] val;
        logic [3:0]  csr_wen;
        logic [31:0] csrd;
        logic        exp_rf_wen;
        logic [31:0] exp_val;
        logic [31:0] exp_csrd;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic rf_wen,
                          input logic [31:0] val, input logic [3:0] csr_wen, input logic [31:0] csrd);
        wb_valid    = 1'b1;
        wb_pc       = pc;
        wb_rd       = rd;
        wb_rf_wen   = rf_wen;
        wb_rd_value = val;
        wb_csr_wen  = csr_wen;
        wb_csrd     = csrd;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        wb_valid    = 1'b0;
        trace_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [TRACE_W-1:0] pack_rec(input logic [15:0] seq, input logic [31:0] pc,
        input logic [4:0] rd, input logic rf_wen, input logic [31:0] val, input logic [3:0] csr_wen,
        input logic [31:0] csrd);
        return {seq, pc, rd, rf_wen, val, csr_wen, csrd};
    endfunction

    initial begin
        trace_rec_t        r;
        logic [TRACE_W-1:0] exp_rec, cur_exp, prev_data;
        logic [TRACE_W-1:0] q [$];
        logic               acc, prev_stall;
        int                 exp_seq, k;
        logic [31:0]        rp, rv, rc;
        logic [4:0]         rrd;
        logic               rwen;
        logic [3:0]         rcsr;

        vecs[0] = '{32'h8000_0000, 5'd5,  1'b1, 32'h0000_1234, 4'h0, 32'h0000_0000, 1'b1, 32'h0000_1234, 32'h0};
        vecs[1] = '{32'h8000_0004, 5'd0,  1'b1, 32'hDEAD_BEEF, 4'h0, 32'h0000_0000, 1'b0, 32'h0,          32'h0};
        vecs[2] = '{32'h8000_0008, 5'd7,  1'b1, 32'h0000_0055, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0055, 32'h0};
        vecs[3] = '{32'h8000_000C, 5'd31, 1'b0, 32'h0000_0077, 4'hA, 32'hCAFE_0001, 1'b0, 32'h0000_0077, 32'hCAFE_0001};

        wb_pc = '0; wb_rd = '0; wb_rf_wen = 1'b0; wb_rd_value = '0; wb_csr_wen = '0; wb_csrd = '0;
        reset = 1'b0; wb_valid = 1'b0; trace_ready = 1'b0;
        #3;
        chk("rst_valid",   160'(s_trace_valid), 160'(0));
        chk("rst_level",   160'(s_level),       160'(0));
        chk("rst_retired", 160'(s_retired),     160'(0));
        chk("rst_dropped", 160'(d_dropped),     160'(0));
        chk("rst_data",    160'(s_trace_data),  160'(0));
        chk("rst_ready",   160'(s_wb_ready),    160'(1));

        // Table-driven single commits with immediate drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            commit(vecs[i].pc, vecs[i].rd, vecs[i].rf_wen, vecs[i].val, vecs[i].csr_wen, vecs[i].csrd);
            trace_ready = 1'b1;
            tick();
            wb_valid = 1'b0;
            exp_rec = pack_rec(16'(i), vecs[i].pc, vecs[i].rd, vecs[i].exp_rf_wen, vecs[i].exp_val,
                               vecs[i].csr_wen, vecs[i].exp_csrd);
            chk("vec_valid",   160'(s_trace_valid), 160'(1));
            chk("vec_data",    160'(s_trace_data),  160'(exp_rec));
            chk("vec_retired", 160'(s_retired),     160'(i + 1));
            chk("vec_level",   160'(s_level),       160'(1));
            tick();
            chk("vec_drained", 160'(s_level),       160'(0));
        end

        // Stall on full.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            commit(32'h1000 + 32'(4 * i), 5'd1, 1'b1, 32'(i), 4'h0, 32'h0);
            tick();
        end
        commit(32'h1000 + 32'd32, 5'd1, 1'b1, 32'd8, 4'h0, 32'h0);
        chk("stall_ready",   160'(s_wb_ready), 160'(0));
        chk("stall_level",   160'(s_level),    160'(8));
        chk("stall_retired", 160'(s_retired),  160'(8));
        tick();
        tick();
        chk("stall_hold_level",   160'(s_level),   160'(8));
        chk("stall_hold_retired", 160'(s_retired), 160'(8));
        trace_ready = 1'b1;
        exp_seq = 0;
        for (int c = 0; c < 20 && exp_seq < 9; c++) begin
            if (s_trace_valid) begin
                r = trace_rec_t'(s_trace_data);
                chk("stall_seq", 160'(r.seq), 160'(exp_seq));
                chk("stall_pc",  160'(r.body.pc), 160'(32'h1000 + 32'(4 * exp_seq)));
                exp_seq++;
            end
            acc = wb_valid & s_wb_ready;
            tick();
            if (acc) wb_valid = 1'b0;
        end
        chk("stall_drain_count", 160'(exp_seq),   160'(9));
        chk("stall_retired9",    160'(s_retired), 160'(9));
        chk("stall_dropped",     160'(s_dropped), 160'(0));

        // Drop on full.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            commit(32'h2000 + 32'(4 * i), 5'd2, 1'b1, 32'(i), 4'h0, 32'h0);
            tick();
        end
        wb_valid = 1'b0;
        chk("drop_level",   160'(d_level),    160'(8));
        chk("drop_dropped", 160'(d_dropped),  160'(2));
        chk("drop_retired", 160'(d_retired),  160'(10));
        chk("drop_ready",   160'(d_wb_ready), 160'(1));
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = trace_rec_t'(d_trace_data);
            chk("drop_valid", 160'(d_trace_valid), 160'(1));
            chk("drop_seq",   160'(r.seq),         160'(i));
            chk("drop_pc",    160'(r.body.pc),     160'(32'h2000 + 32'(4 * i)));
            tick();
        end
        trace_ready = 1'b0;
        chk("drop_empty", 160'(d_level), 160'(0));
        commit(32'h3000, 5'd3, 1'b1, 32'h99, 4'h0, 32'h0);
        tick();
        wb_valid = 1'b0;
        r = trace_rec_t'(d_trace_data);
        chk("drop_next_valid", 160'(d_trace_valid), 160'(1));
        chk("drop_next_seq",   160'(r.seq),         160'(8));
        chk("drop_next_pc",    160'(r.body.pc),     160'(32'h3000));

        // Continuous commit with toggling trace_ready against a scoreboard.
        do_reset();
        k = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        rp = $urandom; rrd = 5'($urandom_range(1, 31)); rwen = 1'($urandom);
        rv = $urandom; rcsr = 4'($urandom_range(1, 15)); rc = $urandom;
        commit(rp, rrd, rwen, rv, rcsr, rc);
        cur_exp = pack_rec(16'(k), rp, rrd, rwen, rv, rcsr, rc);
        for (int c = 0; c < 1000; c++) begin
            trace_ready = c[0];
            if (prev_stall) chk("hold_data", 160'(s_trace_data), 160'(prev_data));
            acc = wb_valid & s_wb_ready;
            if (s_trace_valid && trace_ready) begin
                if (q.size() == 0) chk("sb_underflow", 160'(1), 160'(0));
                else chk("sb_order", 160'(s_trace_data), 160'(q.pop_front()));
            end
            prev_stall = s_trace_valid & ~trace_ready;
            prev_data  = s_trace_data;
            if (acc) q.push_back(cur_exp);
            tick();
            if (acc) begin
                k++;
                rp = $urandom; rrd = 5'($urandom_range(1, 31)); rwen = 1'($urandom);
                rv = $urandom; rcsr = 4'($urandom_range(1, 15)); rc = $urandom;
                commit(rp, rrd, rwen, rv, rcsr, rc);
                cur_exp = pack_rec(16'(k), rp, rrd, rwen, rv, rcsr, rc);
            end
        end
        wb_valid = 1'b0;
        chk("sb_level",   160'(s_level),   160'(q.size()));
        chk("sb_retired", 160'(s_retired), 160'(k));
        chk("sb_progress", 160'(k > 400),  160'(1));

        // Asynchronous reset mid-drain.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            commit(32'h4000 + 32'(4 * i), 5'd4, 1'b1, 32'(i), 4'h1, 32'h5);
            tick();
        end
        wb_valid = 1'b0;
        trace_ready = 1'b1;
        chk("arst_level_pre", 160'(s_level), 160'(5));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid",   160'(s_trace_valid), 160'(0));
        chk("arst_level",   160'(s_level),       160'(0));
        chk("arst_retired", 160'(s_retired),     160'(0));
        chk("arst_data",    160'(s_trace_data),  160'(0));
        tick();
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Retire-side consumer of the writeback stage's commit interface: (valid, pc, rd, rd value, regfile write enable, CSR write enable, CSR data).
- Each committed instruction is captured as a packed trace record and queued in a FIFO.
- Records drain through a valid/ready trace port to the difftest/trace host.
- Maintains a 64-bit retired-instruction counter and a saturating dropped-record counter. Backpressure towards writeback is selectable.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- STALL_ON_FULL, 1, 1 = deassert wb_ready when full; 0 = always ready, drop records when full.
- SEQ_W, 16, width of the per-record sequence number; wraps modulo 2^SEQ_W.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wb_valid  in  1  writeback stage presents a committed instruction.
- wb_pc  in  32  PC of the committed instruction.
- wb_rd  in  5  destination register index.
- wb_rf_wen  in  1  regfile write enable, already qualified by valid.
- wb_rd_value  in  32  value written to rd.
- wb_csr_wen  in  4  CSR write-enable vector.
- wb_csrd  in  32  CSR write data.
- wb_ready  out  1  buffer can accept a commit this cycle.
- trace_valid  out  1  head record available.
- trace_ready  in  1  host consumes the head record.
- trace_data  out  TRACE_W  head record (trace_rec_t, packed).
- retired_cnt  out  64  number of accepted commits.
- dropped_cnt  out  16  records lost to overflow; saturates at 0xFFFF.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, wr_ptr/rd_ptr/level=0, seq=0, retired_cnt=0, dropped_cnt=0, trace_valid=0, trace_data=0.
- wb_ready is combinational:
  - STALL_ON_FULL=1: wb_ready = (level != DEPTH).
  - STALL_ON_FULL=0: wb_ready = 1.
- push = wb_valid & (level != DEPTH). The record is written at the clock edge; seq increments; retired_cnt increments.
- Overflow, STALL_ON_FULL=0 only: wb_valid while level==DEPTH means the record is discarded, dropped_cnt increments (saturating at 0xFFFF), and retired_cnt still increments.
- Overflow, STALL_ON_FULL=1: the producer must hold wb_valid and its data while wb_ready=0. No drop and no count occur on those cycles.
- pop = trace_valid & trace_ready. trace_valid = (level != 0). trace_data shows the head entry directly from storage (first-word-fall-through).
- Latency: a record pushed at edge N is visible on trace_data after edge N when the FIFO was empty, i.e. one cycle from wb_valid to trace_valid.
- Simultaneous push and pop:
  - level unchanged; both pointers advance.
  - When full and STALL_ON_FULL=1, the push is still blocked because wb_ready does not look ahead to the pop.
  - When empty, no pop occurs because trace_valid=0.
- Record normalisation:
  - If wb_rd==0: rf_wen field is forced to 0 and rd_value field to 0.
  - If wb_csr_wen==0: csrd field is forced to 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked separately (0..DEPTH).
- trace_data holds stable while trace_valid=1 and trace_ready=0.
- retired_cnt wraps at 2^64 (not reachable in practice).
- Reset mid-drain: all contents are discarded and the host sees trace_valid fall asynchronously.

Decomposition:
- Shared package trace_pkg holds:
  - typedef trace_rec_t, packed in order {seq[SEQ_W], pc[32], rd[5], rf_wen, rd_value[32], csr_wen[4], csrd[32]}.
  - localparam TRACE_W = $bits(trace_rec_t).
  - localparam DROP_SAT = 16'hFFFF.
- One sub-module, trace_fifo: a generic synchronous FWFT FIFO (parameters WIDTH, DEPTH; ports push/pop/din/dout/level/full/empty; async active-low reset).
- commit_trace_buffer owns normalisation, seq, counters, and the backpressure policy.

Test Plan:
- Reset, then a single commit (pc=0x8000_0000, rd=5, value=0x1234, rf_wen=1) with trace_ready=1 -> trace_valid=1 on the next cycle with seq=0 and those fields; retired_cnt=1; level returns to 0 after the pop.
- Commit with rd=0, rf_wen=1, value=0xDEAD_BEEF -> record shows rf_wen=0 and rd_value=0. Commit with csr_wen=0, csrd=0xFFFF_FFFF -> csrd field 0.
- STALL_ON_FULL=1, trace_ready=0, 9 back-to-back commits -> wb_ready=0 after the 8th push; level=8; retired_cnt=8. Then trace_ready=1 -> all records drain in order with seq 0..7; the 9th is accepted when wb_ready rises.
- STALL_ON_FULL=0, trace_ready=0, 10 commits -> level=8, dropped_cnt=2, retired_cnt=10. Drained seq values are 0..7; the next accepted record has seq=8.
- Continuous commit with trace_ready toggling every cycle for 1000 cycles -> in-order data matching a scoreboard, no loss; trace_data stable during stalls.
- Assert reset with level=5 -> trace_valid, level, and counters go to 0 immediately, without waiting for a clock edge.
